uart_rx_byte: RTL and testbench

Asynchronous serial (8-N-1) receiver that turns the raw UART line into parallel bytes for the password-check stage. It synchronises the line, finds the start bit, samples each bit at its centre, and emits a held byte plus a one-cycle valid strobe. Framing errors are flagged and the previous byte is left unchanged. The held `Uart_out` byte drives the checker's `Uart_in` bus directly.

---
 rtl/uart_rx_byte.sv | 154 +++++++++++++++
 tb/tb_uart_rx_byte.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8-N-1 UART receiver: synchronises Rx_in, samples each bit at its centre and
// presents a held byte with a one-cycle valid strobe, or a one-cycle framing error.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       Clkin,
  input  logic       Rst,
  input  logic       Rx_in,
  output logic [7:0] Uart_out,
  output logic       Rx_valid,
  output logic       Frame_err,
  output logic       Rx_busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic          rx_meta_r;
  logic          rx_sync_r;
  logic          rx_s;
  logic [2:0]    state_r,  state_nxt_s;
  logic [CW-1:0] cnt_r,    cnt_nxt_s;
  logic [2:0]    idx_r,    idx_nxt_s;
  logic [7:0]    shift_r,  shift_nxt_s;
  logic [7:0]    data_r,   data_nxt_s;
  logic          valid_r,  valid_nxt_s;
  logic          err_r,    err_nxt_s;
  logic          busy_r;

  assign rx_s = rx_sync_r;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge Clkin or posedge Rst) begin
    if (Rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= Rx_in;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Frame FSM next-state and datapath; the stop decision returns to IDLE mid stop-bit.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    shift_nxt_s = shift_r;
    data_nxt_s  = data_r;
    valid_nxt_s = 1'b0;
    err_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = CNT_ZERO;
        if (!rx_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_nxt_s = CNT_ZERO;
          idx_nxt_s = 3'd0;
          // A line already back high at mid start-bit was only a glitch.
          if (!rx_s) begin
            state_nxt_s = ST_DATA;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt_s   = CNT_ZERO;
          shift_nxt_s = {rx_s, shift_r[7:1]};
          if (idx_r == 3'd7) begin
            state_nxt_s = ST_STOP;
          end else begin
            idx_nxt_s = idx_r + 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt_s = CNT_ZERO;
          if (rx_s) begin
            data_nxt_s  = shift_r;
            valid_nxt_s = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            err_nxt_s   = 1'b1;
            state_nxt_s = ST_BREAK;
          end
        end else begin
          cnt_nxt_s = cnt_r + 1'b1;
        end
      end
      ST_BREAK: begin
        // Hold off until the line recovers so a stuck-low line is not re-read as starts.
        if (rx_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge Clkin or posedge Rst) begin
    if (Rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      shift_r <= shift_nxt_s;
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
      err_r   <= err_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  assign Uart_out  = data_r;
  assign Rx_valid  = valid_r;
  assign Frame_err = err_r;
  assign Rx_busy   = busy_r;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: serial frames are generated from bit-level
// rules, expected pulses queued at issue time and checked by an independent monitor.
module tb_uart_rx_byte;
  localparam int C = 16;
  localparam int H = C / 2;
  // Line falls after edge N -> rx_s low after edge N+2 (t0 starts); pulse in cycle t0+H+9C+1.
  localparam int PULSE_LAT = 2 + H + 9 * C + 1;

  logic       Clkin = 1'b0;
  logic       Rst   = 1'b0;
  logic       Rx_in = 1'b1;
  logic [7:0] Uart_out;
  logic       Rx_valid;
  logic       Frame_err;
  logic       Rx_busy;

  uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
    .Clkin    (Clkin),
    .Rst      (Rst),
    .Rx_in    (Rx_in),
    .Uart_out (Uart_out),
    .Rx_valid (Rx_valid),
    .Frame_err(Frame_err),
    .Rx_busy  (Rx_busy)
  );

  always #5 Clkin = ~Clkin;

  int cyc = 0;
  always @(posedge Clkin) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         when;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Must be called at posedge+1; drives nbits bits of the frame, ends at posedge+1.
  task automatic send_frame(input logic [7:0] d, input bit stop, input int nbits);
    logic [9:0] bits;
    int         start_cyc;
    bits      = {stop, d, 1'b0};
    start_cyc = cyc;
    if (nbits == 10) begin
      exp_t e;
      e.is_err = !stop;
      e.data   = d;
      e.when   = start_cyc + PULSE_LAT;
      exp_q.push_back(e);
    end
    for (int b = 0; b < nbits; b++) begin
      Rx_in = bits[b];
      repeat (C) @(posedge Clkin);
      #1;
    end
  endtask

  task automatic idle(input int n);
    Rx_in = 1'b1;
    repeat (n) @(posedge Clkin);
    #1;
  endtask

  task automatic wait_neg(input int target);
    @(negedge Clkin);
    while (cyc < target) @(negedge Clkin);
  endtask

  // Monitor: pops the scoreboard on every pulse and tracks the held byte.
  always @(negedge Clkin) begin
    if (Rst) begin
      last_good = 8'h00;
      chk("outputs_in_reset", {21'd0, Uart_out, Rx_valid, Frame_err, Rx_busy}, 32'd0);
    end else begin
      if (Rx_valid || Frame_err) begin
        chk("valid_err_exclusive", {31'd0, Rx_valid & Frame_err}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, Rx_valid, Frame_err}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_kind_err", {31'd0, Frame_err}, {31'd0, e.is_err});
          chk("pulse_cycle", cyc, e.when);
          if (!e.is_err) begin
            chk("rx_byte", {24'd0, Uart_out}, {24'd0, e.data});
            last_good = e.data;
          end
        end
      end
      chk("uart_out_held", {24'd0, Uart_out}, {24'd0, last_good});
    end
  end

  initial begin
    int g;
    #2 Rst = 1'b1;
    repeat (3) @(posedge Clkin);
    #1;
    chk("reset_state", {21'd0, Uart_out, Rx_valid, Frame_err, Rx_busy}, 32'd0);
    Rst = 1'b0;
    idle(5);

    // Single frame 'a'
    send_frame(8'h61, 1'b1, 10);
    idle(20);

    // Back-to-back frames, no idle between
    send_frame(8'h61, 1'b1, 10);
    send_frame(8'h62, 1'b1, 10);
    send_frame(8'h63, 1'b1, 10);
    send_frame(8'h64, 1'b1, 10);
    idle(20);

    // 5-cycle glitch: START rejects it at mid-bit, busy falls at t0+9
    g = cyc;
    Rx_in = 1'b0;
    repeat (5) @(posedge Clkin);
    #1;
    Rx_in = 1'b1;
    wait_neg(g + 10);
    chk("glitch_busy_t0p8", {31'd0, Rx_busy}, 32'd1);
    wait_neg(g + 11);
    chk("glitch_busy_t0p9", {31'd0, Rx_busy}, 32'd0);
    @(posedge Clkin);
    #1;
    idle(10);

    // Framing error then line held low (48 cycles from stop start), then release
    send_frame(8'h55, 1'b0, 10);
    repeat (32) @(posedge Clkin);
    #1;
    chk("break_busy_low_line", {31'd0, Rx_busy}, 32'd1);
    g = cyc;
    Rx_in = 1'b1;
    wait_neg(g + 2);
    chk("break_busy_before_rx_s", {31'd0, Rx_busy}, 32'd1);
    wait_neg(g + 3);
    chk("break_busy_released", {31'd0, Rx_busy}, 32'd0);
    @(posedge Clkin);
    #1;
    idle(10);
    send_frame(8'h41, 1'b1, 10);
    idle(20);

    // Reset during data bit 3 of 0xA5
    send_frame(8'hA5, 1'b1, 4);
    Rx_in = 1'b0;  // data bit 3 of 0xA5
    repeat (8) @(posedge Clkin);
    #2;
    chk("busy_midframe", {31'd0, Rx_busy}, 32'd1);
    chk("byte_before_rst", {24'd0, Uart_out}, 32'h41);
    Rst = 1'b1;
    #1;
    chk("async_reset", {21'd0, Uart_out, Rx_valid, Frame_err, Rx_busy}, 32'd0);
    repeat (3) @(posedge Clkin);
    #1;
    Rx_in = 1'b1;
    Rst   = 1'b0;
    idle(5);
    send_frame(8'h3C, 1'b1, 10);
    idle(20);

    // Reset held with a randomly toggling line
    Rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      Rx_in = 1'($urandom);
      @(posedge Clkin);
      #1;
    end
    Rx_in = 1'b1;
    repeat (3) @(posedge Clkin);
    #1;
    Rst = 1'b0;
    idle(5);

    // Random good frames with random gaps (including none)
    for (int i = 0; i < 10; i++) begin
      send_frame(8'($urandom), 1'b1, 10);
      idle(int'($urandom_range(0, 12)));
    end

    // Drain the scoreboard within a bounded time
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge Clkin);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
